transcription_sequencer: RTL and testbench

TRANSCRIPTION_SEQUENCER -- requirements
Module: transcription_sequencer

---
 rtl/transcription_sequencer.sv | 177 +++++++++++++++++
 tb/tb_transcription_sequencer.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/transcription_sequencer.sv
// -----------------------------------------------------------------------------
// transcription_sequencer
//
// Sequences a note transcription into an external slot buffer. A start request
// first clears every slot (writes 0 to address 0..NUM_SLOTS-1 on consecutive
// cycles). The sequencer then records: every TICK_PERIOD cycles it writes the
// currently held note (last note_in seen with note_valid_in) into the next slot.
// After the last slot it parks in DONE until a new start or a stop.
//
// Ports
//   clk_in         system clock (audio domain)
//   rst_in         asynchronous active-low reset
//   start_in       single-cycle request to begin a new transcription
//   stop_in        single-cycle request to abort / exit (wins over start_in)
//   note_in        note index from the lookup stage (0 = rest)
//   note_valid_in  single-cycle strobe qualifying note_in
//   wr_en_out      single-cycle buffer write strobe
//   wr_addr_out    buffer write address (held while wr_en_out is low)
//   wr_data_out    buffer write data (held while wr_en_out is low)
//   busy_out       high while clearing or recording
//   done_out       high once every slot has been recorded
//   slot_out       index of the next slot to be recorded (saturates)
// -----------------------------------------------------------------------------
module transcription_sequencer #(
    parameter int NUM_SLOTS   = 160,
    parameter int NOTE_WIDTH  = 6,
    parameter int TICK_PERIOD = 34816000,
    parameter int CNT_WIDTH   = 26
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic                         start_in,
    input  logic                         stop_in,
    input  logic [NOTE_WIDTH-1:0]        note_in,
    input  logic                         note_valid_in,
    output logic                         wr_en_out,
    output logic [$clog2(NUM_SLOTS)-1:0] wr_addr_out,
    output logic [NOTE_WIDTH-1:0]        wr_data_out,
    output logic                         busy_out,
    output logic                         done_out,
    output logic [$clog2(NUM_SLOTS)-1:0] slot_out
);

    localparam int                   AW        = $clog2(NUM_SLOTS);
    localparam logic [AW-1:0]        LAST_SLOT = AW'(NUM_SLOTS - 1);
    localparam logic [CNT_WIDTH-1:0] TICK_LAST = CNT_WIDTH'(TICK_PERIOD - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CLEAR  = 2'd1,
        S_RECORD = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic                    wr_en_q, wr_en_d;
    logic [AW-1:0]           wr_addr_q, wr_addr_d;
    logic [NOTE_WIDTH-1:0]   wr_data_q, wr_data_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic [AW-1:0]           slot_q, slot_d;
    logic [CNT_WIDTH-1:0]    tick_q, tick_d;
    logic [NOTE_WIDTH-1:0]   held_q, held_d;

    logic wrap;
    logic last_wr;

    assign wrap    = (tick_q == TICK_LAST);
    // In RECORD, wr_en_q is only ever set by a slot write, so seeing the write
    // to the final slot on the outputs means recording is complete. Moving to
    // DONE one cycle later keeps wr_en_out low for the whole of DONE.
    assign last_wr = wr_en_q && (wr_addr_q == LAST_SLOT);

    // State and registered outputs
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q   <= S_IDLE;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            slot_q    <= '0;
            tick_q    <= '0;
            held_q    <= '0;
        end else begin
            state_q   <= state_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            slot_q    <= slot_d;
            tick_q    <= tick_d;
            held_q    <= held_d;
        end
    end

    // Next-state logic; stop_in always wins over start_in
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (start_in && !stop_in) state_d = S_CLEAR;
            end
            S_CLEAR: begin
                if (stop_in)                       state_d = S_IDLE;
                else if (wr_addr_q == LAST_SLOT)   state_d = S_RECORD;
            end
            S_RECORD: begin
                if (stop_in)       state_d = S_IDLE;
                else if (last_wr)  state_d = S_DONE;
            end
            S_DONE: begin
                if (stop_in)       state_d = S_IDLE;
                else if (start_in) state_d = S_CLEAR;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Next values of the registered outputs and datapath, keyed on the
    // transition being taken so every output is valid in the new state.
    always_comb begin
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        slot_d    = slot_q;
        tick_d    = tick_q;
        held_d    = held_q;
        busy_d    = (state_d == S_CLEAR) || (state_d == S_RECORD);
        done_d    = (state_d == S_DONE);

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (state_d == S_CLEAR) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = '0;
                    wr_data_d = '0;
                end
            end
            S_CLEAR: begin
                if (state_d == S_CLEAR) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = wr_addr_q + AW'(1);
                    wr_data_d = '0;
                end else if (state_d == S_RECORD) begin
                    tick_d = '0;
                    slot_d = '0;
                    held_d = '0;
                end
            end
            S_RECORD: begin
                if (state_d == S_RECORD) begin
                    tick_d = wrap ? '0 : tick_q + CNT_WIDTH'(1);
                    if (note_valid_in) held_d = note_in;
                    if (wrap) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = slot_q;
                        // A note arriving on the wrap cycle is what gets written.
                        wr_data_d = note_valid_in ? note_in : held_q;
                        if (slot_q != LAST_SLOT) slot_d = slot_q + AW'(1);
                    end
                end
            end
            default: ;
        endcase
    end

    assign wr_en_out   = wr_en_q;
    assign wr_addr_out = wr_addr_q;
    assign wr_data_out = wr_data_q;
    assign busy_out    = busy_q;
    assign done_out    = done_q;
    assign slot_out    = slot_q;

endmodule

// File: tb/tb_transcription_sequencer.sv
module tb_transcription_sequencer;

    localparam int NS   = 8;
    localparam int TP   = 4;
    localparam int NW   = 6;
    localparam int CW   = 26;
    localparam int AW   = 3;
    localparam int NCYC = NS * TP;

    logic          clk_in        = 1'b0;
    logic          rst_in        = 1'b0;
    logic          start_in      = 1'b0;
    logic          stop_in       = 1'b0;
    logic [NW-1:0] note_in       = '0;
    logic          note_valid_in = 1'b0;
    logic          wr_en_out;
    logic [AW-1:0] wr_addr_out;
    logic [NW-1:0] wr_data_out;
    logic          busy_out;
    logic          done_out;
    logic [AW-1:0] slot_out;

    int checks   = 0;
    int failures = 0;

    // Write log kept by an observer of the buffer port
    int            wr_count = 0;
    logic [NW-1:0] mem [NS];

    // Stimulus / reference model state
    int ev [NCYC];          // note event per RECORD cycle, -1 = none
    int exp_data [NS];      // expected final content of each slot

    transcription_sequencer #(
        .NUM_SLOTS  (NS),
        .NOTE_WIDTH (NW),
        .TICK_PERIOD(TP),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .start_in     (start_in),
        .stop_in      (stop_in),
        .note_in      (note_in),
        .note_valid_in(note_valid_in),
        .wr_en_out    (wr_en_out),
        .wr_addr_out  (wr_addr_out),
        .wr_data_out  (wr_data_out),
        .busy_out     (busy_out),
        .done_out     (done_out),
        .slot_out     (slot_out)
    );

    always #5 clk_in = ~clk_in;

    always @(negedge clk_in) begin
        if (wr_en_out === 1'b1) begin
            wr_count           <= wr_count + 1;
            mem[wr_addr_out]   <= wr_data_out;
        end
    end

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic clear_events();
        for (int i = 0; i < NCYC; i++) ev[i] = -1;
    endtask

    // Start a transcription, check the clear sweep, then record using ev[].
    // The model: slot k is written at RECORD cycle TP*(k+1) with the last note
    // presented at or before cycle TP*(k+1)-1 (0 if none). stop_at >= 0 asserts
    // stop_in at that RECORD cycle and ends the session there.
    task automatic run_session(input int stop_at, input string tag);
        int   held;
        int   exp_slot;
        logic exp_wr;
        start_in = 1'b1;
        step();
        start_in = 1'b0;
        for (int i = 0; i < NS; i++) begin
            checks++;
            if (wr_en_out !== 1'b1 || wr_addr_out !== AW'(i) || wr_data_out !== '0 ||
                busy_out !== 1'b1 || done_out !== 1'b0) begin
                failures++;
                $display("FAIL %s_clear[%0d]: en=%b addr=%0d data=%0d busy=%b done=%b, required en=1 addr=%0d data=0 busy=1 done=0",
                         tag, i, wr_en_out, wr_addr_out, wr_data_out, busy_out, done_out, i);
            end
            step();
        end
        held = 0;
        checks++;
        if (wr_en_out !== 1'b0 || busy_out !== 1'b1 || slot_out !== '0 || done_out !== 1'b0) begin
            failures++;
            $display("FAIL %s_rec_entry: en=%b busy=%b slot=%0d done=%b, required en=0 busy=1 slot=0 done=0",
                     tag, wr_en_out, busy_out, slot_out, done_out);
        end
        for (int j = 0; j < NCYC; j++) begin
            if (ev[j] >= 0) begin
                note_in       = NW'(ev[j]);
                note_valid_in = 1'b1;
                held          = ev[j];
            end
            if (j == stop_at) stop_in = 1'b1;
            step();
            note_valid_in = 1'b0;
            stop_in       = 1'b0;
            if (j == stop_at) begin
                checks++;
                if (wr_en_out !== 1'b0 || busy_out !== 1'b0 || done_out !== 1'b0) begin
                    failures++;
                    $display("FAIL %s_stop@%0d: en=%b busy=%b done=%b, required en=0 busy=0 done=0",
                             tag, j, wr_en_out, busy_out, done_out);
                end
                return;
            end
            exp_wr   = ((j + 1) % TP == 0);
            exp_slot = (j + 1) / TP;
            if (exp_slot > NS - 1) exp_slot = NS - 1;
            checks++;
            if (wr_en_out !== exp_wr || slot_out !== AW'(exp_slot) || busy_out !== 1'b1 ||
                done_out !== 1'b0 ||
                (exp_wr && (wr_addr_out !== AW'((j + 1) / TP - 1) || wr_data_out !== NW'(held)))) begin
                failures++;
                $display("FAIL %s_rec_cyc%0d: en=%b addr=%0d data=%0d slot=%0d busy=%b done=%b, required en=%b addr=%0d data=%0d slot=%0d busy=1 done=0",
                         tag, j + 1, wr_en_out, wr_addr_out, wr_data_out, slot_out, busy_out, done_out,
                         exp_wr, exp_wr ? (j + 1) / TP - 1 : wr_addr_out, held, exp_slot);
            end
            if (exp_wr) exp_data[(j + 1) / TP - 1] = held;
        end
        step();
        checks++;
        if (wr_en_out !== 1'b0 || busy_out !== 1'b0 || done_out !== 1'b1) begin
            failures++;
            $display("FAIL %s_done: en=%b busy=%b done=%b, required en=0 busy=0 done=1",
                     tag, wr_en_out, busy_out, done_out);
        end
        for (int k = 0; k < NS; k++) begin
            checks++;
            if (mem[k] !== NW'(exp_data[k])) begin
                failures++;
                $display("FAIL %s_slot%0d: got %0d, required %0d", tag, k, mem[k], exp_data[k]);
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk_in);
        #1;
        checks++;
        if (wr_en_out !== 1'b0 || wr_addr_out !== '0 || wr_data_out !== '0 || busy_out !== 1'b0 ||
            done_out !== 1'b0 || slot_out !== '0) begin
            failures++;
            $display("FAIL reset_values: en=%b addr=%0d data=%0d busy=%b done=%b slot=%0d, required all 0",
                     wr_en_out, wr_addr_out, wr_data_out, busy_out, done_out, slot_out);
        end
        rst_in = 1'b1;
        repeat (5) step();
        checks++;
        if (busy_out !== 1'b0 || wr_count !== 0) begin
            failures++;
            $display("FAIL idle_after_reset: busy=%b writes=%0d, required busy=0 writes=0", busy_out, wr_count);
        end
    endtask

    task automatic test_clear_record();
        clear_events();
        ev[1] = 5;
        ev[6] = 9;
        run_session(-1, "spec");
        checks++;
        if (mem[0] !== 6'd5 || mem[1] !== 6'd9 || mem[2] !== 6'd9) begin
            failures++;
            $display("FAIL spec_first_slots: got %0d %0d %0d, required 5 9 9", mem[0], mem[1], mem[2]);
        end
        for (int k = 3; k < NS; k++) begin
            checks++;
            if (mem[k] !== 6'd9) begin
                failures++;
                $display("FAIL spec_tail_slot%0d: got %0d, required 9", k, mem[k]);
            end
        end
    endtask

    task automatic test_done_hold();
        int c0;
        c0 = wr_count;
        note_in = 6'd33;
        note_valid_in = 1'b1;
        step();
        note_valid_in = 1'b0;
        repeat (6) step();
        checks++;
        if (done_out !== 1'b1 || busy_out !== 1'b0 || wr_en_out !== 1'b0 || wr_count !== c0) begin
            failures++;
            $display("FAIL done_hold: done=%b busy=%b en=%b writes=%0d, required done=1 busy=0 en=0 writes=%0d",
                     done_out, busy_out, wr_en_out, wr_count, c0);
        end
    endtask

    task automatic test_restart();
        clear_events();
        ev[13] = 17;
        run_session(-1, "restart");
        checks++;
        if (mem[0] !== 6'd0 || mem[2] !== 6'd0 || mem[3] !== 6'd17) begin
            failures++;
            $display("FAIL restart_rest: got %0d %0d %0d, required 0 0 17", mem[0], mem[2], mem[3]);
        end
    endtask

    task automatic test_coincidence();
        clear_events();
        ev[2] = 3;
        ev[7] = 12;
        run_session(-1, "coinc");
        checks++;
        if (mem[0] !== 6'd3 || mem[1] !== 6'd12) begin
            failures++;
            $display("FAIL coinc_slots: got %0d %0d, required 3 12", mem[0], mem[1]);
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 3; r++) begin
            clear_events();
            for (int e = 0; e < 5; e++) ev[$urandom_range(NCYC - 1, 0)] = $urandom_range(63, 1);
            run_session(-1, $sformatf("rand%0d", r));
        end
    endtask

    task automatic test_abort();
        int c0;
        clear_events();
        ev[0] = 7;
        run_session(7, "abort");
        c0 = wr_count;
        for (int i = 0; i < 8; i++) begin
            note_in       = NW'($urandom_range(63, 0));
            note_valid_in = 1'b1;
            step();
        end
        note_valid_in = 1'b0;
        checks++;
        if (wr_count !== c0 || busy_out !== 1'b0 || done_out !== 1'b0) begin
            failures++;
            $display("FAIL abort_idle: writes=%0d busy=%b done=%b, required writes=%0d busy=0 done=0",
                     wr_count, busy_out, done_out, c0);
        end
        checks++;
        if (mem[0] !== 6'd7) begin
            failures++;
            $display("FAIL abort_slot0: got %0d, required 7", mem[0]);
        end
        start_in = 1'b1;
        stop_in  = 1'b1;
        step();
        start_in = 1'b0;
        stop_in  = 1'b0;
        repeat (3) step();
        checks++;
        if (busy_out !== 1'b0 || wr_en_out !== 1'b0 || wr_count !== c0) begin
            failures++;
            $display("FAIL start_stop_idle: busy=%b en=%b writes=%0d, required busy=0 en=0 writes=%0d",
                     busy_out, wr_en_out, wr_count, c0);
        end
        // stop during the clear sweep
        start_in = 1'b1;
        step();
        start_in = 1'b0;
        step();
        stop_in = 1'b1;
        start_in = 1'b1;
        step();
        stop_in = 1'b0;
        start_in = 1'b0;
        repeat (3) step();
        checks++;
        if (busy_out !== 1'b0 || wr_en_out !== 1'b0 || wr_count !== c0 + 2) begin
            failures++;
            $display("FAIL clear_stop: busy=%b en=%b writes=%0d, required busy=0 en=0 writes=%0d",
                     busy_out, wr_en_out, wr_count, c0 + 2);
        end
    endtask

    task automatic test_reset_mid_clear();
        int c0;
        c0 = wr_count;
        start_in = 1'b1;
        step();
        start_in = 1'b0;
        repeat (3) step();
        checks++;
        if (wr_en_out !== 1'b1 || wr_addr_out !== 3'd3) begin
            failures++;
            $display("FAIL rstclr_at3: en=%b addr=%0d, required en=1 addr=3", wr_en_out, wr_addr_out);
        end
        #5;
        rst_in = 1'b0;
        #1;
        checks++;
        if (wr_en_out !== 1'b0 || wr_addr_out !== '0 || wr_data_out !== '0 || busy_out !== 1'b0 ||
            done_out !== 1'b0 || slot_out !== '0) begin
            failures++;
            $display("FAIL rstclr_async: en=%b addr=%0d data=%0d busy=%b done=%b slot=%0d, required all 0",
                     wr_en_out, wr_addr_out, wr_data_out, busy_out, done_out, slot_out);
        end
        @(posedge clk_in);
        @(posedge clk_in);
        #3;
        rst_in = 1'b1;
        repeat (6) step();
        checks++;
        if (wr_count !== c0 + 4 || busy_out !== 1'b0) begin
            failures++;
            $display("FAIL rstclr_nowrite: writes=%0d busy=%b, required writes=%0d busy=0",
                     wr_count, busy_out, c0 + 4);
        end
    endtask

    initial begin
        test_reset();
        test_clear_record();
        test_done_hold();
        test_restart();
        test_coincidence();
        test_random();
        test_abort();
        test_reset_mid_clear();
        clear_events();
        run_session(-1, "post_reset");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
